mcycle_control: RTL and testbench

- Multicycle control FSM that drives every control input of the 16-bit `datapath` block and of the memory port.
- Decodes the fetched instruction and holds the latched PSR flags.
- Sequences fetch, decode, execute, memory and write-back cycles.
- Sits beside `datapath` in the CPU top level: it consumes `instruction` and `psr_flags` and produces the select, enable and ALU-op signals that `datapath` consumes.

---
 rtl/mcycle_control_if.sv | 31 +++
 rtl/mcycle_control.sv | 238 +++++++++++++++++++++++
 tb/tb_mcycle_control.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_control_if.sv
// Control bus between mcycle_control (master) and the datapath/memory port (slave).
interface mcycle_control_if #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned ALU_CONT_BITS = 5
);
    logic [WIDTH-1:0]         instruction;
    logic [WIDTH-1:0]         psr_flags;
    logic                     reg_write;
    logic                     pc_en;
    logic                     alu_A_src;
    logic [1:0]               alu_B_src;
    logic                     pc_src;
    logic                     reg_write_src;
    logic                     destination_reg;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic                     mem_addr_src;
    logic                     mem_write;
    logic                     illegal;

    modport master (
        input  instruction, psr_flags,
        output reg_write, pc_en, alu_A_src, alu_B_src, pc_src, reg_write_src,
               destination_reg, alu_cont, mem_addr_src, mem_write, illegal
    );

    modport slave (
        output instruction, psr_flags,
        input  reg_write, pc_en, alu_A_src, alu_B_src, pc_src, reg_write_src,
               destination_reg, alu_cont, mem_addr_src, mem_write, illegal
    );
endinterface

// File: rtl/mcycle_control.sv
// Multicycle control FSM for the 16-bit datapath and memory port.
// Optional feature: define MCYCLE_TRAP_ILLEGAL_EN to halt on an illegal instruction.
module mcycle_control #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned ALU_CONT_BITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    mcycle_control_if.master  bus
);
    localparam logic [ALU_CONT_BITS-1:0] ALU_ADD   = ALU_CONT_BITS'(0);
    localparam logic [ALU_CONT_BITS-1:0] ALU_SUB   = ALU_CONT_BITS'(1);
    localparam logic [ALU_CONT_BITS-1:0] ALU_AND   = ALU_CONT_BITS'(2);
    localparam logic [ALU_CONT_BITS-1:0] ALU_OR    = ALU_CONT_BITS'(3);
    localparam logic [ALU_CONT_BITS-1:0] ALU_XOR   = ALU_CONT_BITS'(4);
    localparam logic [ALU_CONT_BITS-1:0] ALU_PASSB = ALU_CONT_BITS'(5);
    localparam logic [ALU_CONT_BITS-1:0] ALU_PASSA = ALU_CONT_BITS'(6);
    localparam logic [ALU_CONT_BITS-1:0] ALU_LUI   = ALU_CONT_BITS'(7);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM_RD, S_MEM_WAIT, S_LOAD_WB,
        S_MEM_WR, S_BR_CALC, S_BR_TAKE, S_JUMP, S_LINK, S_LINK_WB, S_HALT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ir;
    logic             flag_c, flag_l, flag_f, flag_z, flag_n;

    // ALU-class function codes shared by the R-type ext field and the I-type opcode
    function automatic logic is_alu_code(input logic [3:0] code);
        return code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    endfunction

    // Fields of the instruction arriving from memory during DECODE
    logic [3:0] in_op, in_cond, in_ext;
    logic dec_alu, dec_load, dec_stor, dec_jal, dec_jcond, dec_bcond, dec_legal, cond_true;
    assign in_op   = bus.instruction[15:12];
    assign in_cond = bus.instruction[11:8];
    assign in_ext  = bus.instruction[7:4];

    assign dec_alu   = ((in_op == 4'h0) && is_alu_code(in_ext)) || is_alu_code(in_op) || (in_op == 4'hF);
    assign dec_load  = (in_op == 4'h4) && (in_ext == 4'h0);
    assign dec_stor  = (in_op == 4'h4) && (in_ext == 4'h4);
    assign dec_jal   = (in_op == 4'h4) && (in_ext == 4'h8);
    assign dec_jcond = (in_op == 4'h4) && (in_ext == 4'hC);
    assign dec_bcond = (in_op == 4'hC);
    assign dec_legal = dec_alu | dec_load | dec_stor | dec_jal | dec_jcond | dec_bcond;

    // Branch/jump condition evaluated on the latched flags
    always_comb begin
        cond_true = 1'b0;
        case (in_cond)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_l;
            4'h5: cond_true = !flag_l;
            4'h6: cond_true = flag_n;
            4'h7: cond_true = !flag_n;
            4'h8: cond_true = flag_f;
            4'h9: cond_true = !flag_f;
            4'hA: cond_true = !flag_l && !flag_z;
            4'hB: cond_true = flag_l || flag_z;
            4'hC: cond_true = !flag_n && !flag_z;
            4'hD: cond_true = flag_n || flag_z;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Latched-instruction decode used from EXEC onwards
    logic [3:0]               ir_code;
    logic                     ir_rtype, ir_is_cmp, ir_sets_flags;
    logic [ALU_CONT_BITS-1:0] ir_alu_op;
    assign ir_rtype      = (ir[15:12] == 4'h0);
    assign ir_code       = ir_rtype ? ir[7:4] : ir[15:12];
    assign ir_is_cmp     = (ir_code == 4'hB);
    assign ir_sets_flags = ir_code inside {4'h5, 4'h9, 4'hB};

    // Function code to ALU operation
    always_comb begin
        ir_alu_op = ALU_ADD;
        case (ir_code)
            4'h1: ir_alu_op = ALU_AND;
            4'h2: ir_alu_op = ALU_OR;
            4'h3: ir_alu_op = ALU_XOR;
            4'h5: ir_alu_op = ALU_ADD;
            4'h9: ir_alu_op = ALU_SUB;
            4'hB: ir_alu_op = ALU_SUB;
            4'hD: ir_alu_op = ALU_PASSB;
            4'hF: ir_alu_op = ALU_LUI;
            default: ir_alu_op = ALU_ADD;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Instruction latch (end of DECODE) and PSR flag capture (end of flag-setting EXEC)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir     <= '0;
            flag_c <= 1'b0;
            flag_l <= 1'b0;
            flag_f <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (state == S_DECODE) ir <= bus.instruction;
            if ((state == S_EXEC) && ir_sets_flags) begin
                flag_c <= bus.psr_flags[0];
                flag_l <= bus.psr_flags[2];
                flag_f <= bus.psr_flags[5];
                flag_z <= bus.psr_flags[6];
                flag_n <= bus.psr_flags[7];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (dec_alu)        state_n = S_EXEC;
                else if (dec_load)  state_n = S_MEM_RD;
                else if (dec_stor)  state_n = S_MEM_WR;
                else if (dec_bcond) state_n = cond_true ? S_BR_CALC : S_FETCH;
                else if (dec_jcond) state_n = cond_true ? S_JUMP : S_FETCH;
                else if (dec_jal)   state_n = S_LINK;
                else begin
`ifdef MCYCLE_TRAP_ILLEGAL_EN
                    state_n = S_HALT;
`else
                    state_n = S_FETCH;
`endif
                end
            end
            S_EXEC:     state_n = ir_is_cmp ? S_FETCH : S_WB;
            S_WB:       state_n = S_FETCH;
            S_MEM_RD:   state_n = S_MEM_WAIT;
            S_MEM_WAIT: state_n = S_LOAD_WB;
            S_LOAD_WB:  state_n = S_FETCH;
            S_MEM_WR:   state_n = S_FETCH;
            S_BR_CALC:  state_n = S_BR_TAKE;
            S_BR_TAKE:  state_n = S_FETCH;
            S_JUMP:     state_n = S_FETCH;
            S_LINK:     state_n = S_LINK_WB;
            S_LINK_WB:  state_n = S_FETCH;
`ifdef MCYCLE_TRAP_ILLEGAL_EN
            S_HALT:     state_n = S_HALT;
`endif
            default:    state_n = S_FETCH;
        endcase
    end

    logic                     reg_write_c, pc_en_c, alu_a_src_c, pc_src_c;
    logic                     reg_write_src_c, mem_addr_src_c, mem_write_c, illegal_c;
    logic [1:0]               alu_b_src_c;
    logic [ALU_CONT_BITS-1:0] alu_cont_c;

    // Moore output decode; enables are forced low while reset is held
    always_comb begin
        reg_write_c     = 1'b0;
        pc_en_c         = 1'b0;
        alu_a_src_c     = 1'b0;
        alu_b_src_c     = 2'd0;
        pc_src_c        = 1'b0;
        reg_write_src_c = 1'b0;
        alu_cont_c      = ALU_ADD;
        mem_addr_src_c  = 1'b0;
        mem_write_c     = 1'b0;
        illegal_c       = 1'b0;
        case (state)
            S_FETCH: alu_b_src_c = 2'd2;
            S_DECODE: begin
                pc_en_c   = 1'b1;
                illegal_c = !dec_legal;
            end
            S_EXEC: begin
                alu_a_src_c = 1'b1;
                alu_b_src_c = ir_rtype ? 2'd0 : 2'd1;
                alu_cont_c  = ir_alu_op;
            end
            S_WB:       reg_write_c = 1'b1;
            S_MEM_RD:   mem_addr_src_c = 1'b1;
            S_MEM_WAIT: mem_addr_src_c = 1'b1;
            S_LOAD_WB: begin
                reg_write_c     = 1'b1;
                reg_write_src_c = 1'b1;
            end
            S_MEM_WR: begin
                mem_addr_src_c = 1'b1;
                mem_write_c    = 1'b1;
            end
            S_BR_CALC: alu_b_src_c = 2'd1;
            S_BR_TAKE: pc_en_c = 1'b1;
            S_JUMP: begin
                pc_en_c  = 1'b1;
                pc_src_c = 1'b1;
            end
            S_LINK: alu_cont_c = ALU_PASSA;
            S_LINK_WB: begin
                reg_write_c = 1'b1;
                pc_en_c     = 1'b1;
                pc_src_c    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            reg_write_c = 1'b0;
            pc_en_c     = 1'b0;
            mem_write_c = 1'b0;
        end
    end

    assign bus.reg_write       = reg_write_c;
    assign bus.pc_en           = pc_en_c;
    assign bus.alu_A_src       = alu_a_src_c;
    assign bus.alu_B_src       = alu_b_src_c;
    assign bus.pc_src          = pc_src_c;
    assign bus.reg_write_src   = reg_write_src_c;
    assign bus.destination_reg = 1'b0;
    assign bus.alu_cont        = alu_cont_c;
    assign bus.mem_addr_src    = mem_addr_src_c;
    assign bus.mem_write       = mem_write_c;
    assign bus.illegal         = illegal_c;

    // Fields not needed for control sequencing
    logic unused_bits;
    assign unused_bits = ^{bus.instruction[3:0], ir[11:8], ir[3:0], bus.psr_flags[15:8],
                           bus.psr_flags[4:3], bus.psr_flags[1]};
endmodule

// File: tb/tb_mcycle_control.sv
// Self-checking bench for mcycle_control: directed cases plus random instruction mix
// compared cycle by cycle against a per-instruction expected control trace.
module tb_mcycle_control;
    typedef struct packed {
        logic       reg_write;
        logic       pc_en;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic       pc_src;
        logic       reg_write_src;
        logic       destination_reg;
        logic [4:0] alu_cont;
        logic       mem_addr_src;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [15:0] cur_instr;
    bit   fc, fl, ff, fz, fn;

    mcycle_control_if #(.WIDTH(16), .ALU_CONT_BITS(5)) bus ();
    mcycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    ctrl_t obs;
    assign obs = {bus.reg_write, bus.pc_en, bus.alu_A_src, bus.alu_B_src, bus.pc_src,
                  bus.reg_write_src, bus.destination_reg, bus.alu_cont, bus.mem_addr_src,
                  bus.mem_write, bus.illegal};

    always #5 clk = ~clk;

    function automatic ctrl_t fetch_exp();
        ctrl_t e = '0;
        e.alu_b_src = 2'd2;
        return e;
    endfunction

    // ALU operation named by the instruction's function code
    function automatic logic [4:0] alu_of(input logic [3:0] code);
        case (code)
            4'h1: return 5'd2;
            4'h2: return 5'd3;
            4'h3: return 5'd4;
            4'h5: return 5'd0;
            4'h9: return 5'd1;
            4'hB: return 5'd1;
            4'hD: return 5'd5;
            4'hF: return 5'd7;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit cond_ok(input logic [3:0] c);
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fl;
            4'h5: return !fl;
            4'h6: return fn;
            4'h7: return !fn;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !fl && !fz;
            4'hB: return fl || fz;
            4'hC: return !fn && !fz;
            4'hD: return fn || fz;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input ctrl_t e);
        #1;
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s instr=%h: observed %h expected %h", tag, cur_instr, obs, e);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        check("reset", fetch_exp());
        @(negedge clk);
        reset = 1'b0;
        {fc, fl, ff, fz, fn} = '0;
    endtask

    // Runs one instruction from its FETCH cycle to the start of the next FETCH
    task automatic run_instr(input logic [15:0] instr, input logic [15:0] psr);
        logic [3:0] op, cond, ext, code;
        bit is_r, is_i, is_m, is_b, legal;
        ctrl_t e;
        ctrl_t q[$];
        string t[$];
        op = instr[15:12]; cond = instr[11:8]; ext = instr[7:4];
        is_r  = (op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD});
        is_i  = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
        is_m  = (op == 4'h4) && (ext inside {4'h0, 4'h4, 4'h8, 4'hC});
        is_b  = (op == 4'hC);
        legal = is_r || is_i || is_m || is_b;
        code  = is_r ? ext : op;
        cur_instr = instr;
        bus.instruction = instr;
        bus.psr_flags   = psr;

        q.push_back(fetch_exp()); t.push_back("FETCH");
        e = '0; e.pc_en = 1'b1; e.illegal = !legal;
        q.push_back(e); t.push_back("DECODE");
        if (is_r || is_i) begin
            e = '0; e.alu_a_src = 1'b1; e.alu_b_src = is_r ? 2'd0 : 2'd1; e.alu_cont = alu_of(code);
            q.push_back(e); t.push_back("EXEC");
            if (code != 4'hB) begin
                e = '0; e.reg_write = 1'b1;
                q.push_back(e); t.push_back("WB");
            end
        end else if (is_m) begin
            case (ext)
                4'h0: begin
                    e = '0; e.mem_addr_src = 1'b1;
                    q.push_back(e); t.push_back("MEM_RD");
                    q.push_back(e); t.push_back("MEM_WAIT");
                    e = '0; e.reg_write = 1'b1; e.reg_write_src = 1'b1;
                    q.push_back(e); t.push_back("LOAD_WB");
                end
                4'h4: begin
                    e = '0; e.mem_addr_src = 1'b1; e.mem_write = 1'b1;
                    q.push_back(e); t.push_back("MEM_WR");
                end
                4'h8: begin
                    e = '0; e.alu_cont = 5'd6;
                    q.push_back(e); t.push_back("LINK");
                    e = '0; e.reg_write = 1'b1; e.pc_en = 1'b1; e.pc_src = 1'b1;
                    q.push_back(e); t.push_back("LINK_WB");
                end
                default: begin
                    if (cond_ok(cond)) begin
                        e = '0; e.pc_en = 1'b1; e.pc_src = 1'b1;
                        q.push_back(e); t.push_back("JUMP");
                    end
                end
            endcase
        end else if (is_b && cond_ok(cond)) begin
            e = '0; e.alu_b_src = 2'd1;
            q.push_back(e); t.push_back("BR_CALC");
            e = '0; e.pc_en = 1'b1;
            q.push_back(e); t.push_back("BR_TAKE");
        end

        foreach (q[i]) begin
            check(t[i], q[i]);
            @(negedge clk);
        end

        if ((is_r || is_i) && (code inside {4'h5, 4'h9, 4'hB}))
            {fc, fl, ff, fz, fn} = {psr[0], psr[2], psr[5], psr[6], psr[7]};

        if (!legal) begin
`ifdef MCYCLE_TRAP_ILLEGAL_EN
            for (int k = 0; k < 10; k++) begin
                check("HALT", '0);
                @(negedge clk);
            end
            apply_reset();
`endif
        end
    endtask

    logic [3:0] r_ext [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0] i_op  [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};

    initial begin
        ctrl_t e;
        logic [15:0] instr;
        int k;
        clk = 1'b0;
        reset = 1'b1;
        n_checks = 0;
        n_fail = 0;
        cur_instr = '0;
        {fc, fl, ff, fz, fn} = '0;
        bus.instruction = '0;
        bus.psr_flags = '0;
        @(negedge clk);
        @(negedge clk);
        apply_reset();

        run_instr(16'h0354, 16'h0000);   // ADD R3,R4
        run_instr(16'hB305, 16'h0040);   // CMPI, Z=1
        run_instr(16'hC0FC, 16'h0000);   // BEQ taken
        run_instr(16'hC1FC, 16'h0000);   // BNE not taken
        run_instr(16'h4102, 16'h0000);   // LOAD
        run_instr(16'h4142, 16'h0000);   // STOR
        run_instr(16'h4285, 16'h0000);   // JAL
        run_instr(16'h4EC3, 16'h0000);   // JUC taken
        run_instr(16'h4FC3, 16'h0000);   // never-condition jump
        run_instr(16'hF1AB, 16'h0000);   // LUI
        run_instr(16'h7000, 16'h0000);   // illegal

        // Reset in EXEC of an ADD: abort at once, and the latched Z must clear
        run_instr(16'hB305, 16'h0040);
        cur_instr = 16'h0354;
        bus.instruction = 16'h0354;
        bus.psr_flags = 16'h0040;
        check("FETCH", fetch_exp());
        @(negedge clk);
        e = '0; e.pc_en = 1'b1;
        check("DECODE", e);
        @(negedge clk);
        e = '0; e.alu_a_src = 1'b1; e.alu_cont = 5'd0;
        check("EXEC", e);
        reset = 1'b1;
        check("reset_in_exec", fetch_exp());
        @(negedge clk);
        reset = 1'b0;
        {fc, fl, ff, fz, fn} = '0;
        run_instr(16'hC0FC, 16'h0000);   // BEQ not taken after reset

        for (int n = 0; n < 300; n++) begin
            instr = 16'($urandom);
            k = int'($urandom_range(0, 5));
            case (k)
                0: begin instr[15:12] = 4'h0; instr[7:4] = r_ext[$urandom_range(0, 6)]; end
                1: instr[15:12] = i_op[$urandom_range(0, 7)];
                2: begin instr[15:12] = 4'h4; instr[7:4] = {2'($urandom_range(0, 3)), 2'b00}; end
                3: instr[15:12] = 4'hC;
                default: ;
            endcase
            run_instr(instr, 16'($urandom));
        end
        check("FETCH_final", fetch_exp());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
